// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Segment patterns are active-high in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Digit index doubles as the scan FSM state.
  typedef enum logic [1:0] {
    DIGIT_0 = 2'd0,
    DIGIT_1 = 2'd1,
    DIGIT_2 = 2'd2,
    DIGIT_3 = 2'd3
  } digit_idx_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Count input and display pin bundle of the scan driver.
// slave = the driver, master = whoever feeds the count and watches the pins.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [NUM_DIGITS*4-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_tick;

  modport master (
    output bcd_in, dp_in,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  bcd_in, dp_in,
    output an, seg, dp, frame_tick
  );

endinterface

// File: rtl/seg7_decoder.sv
// Nibble to active-high seven-segment pattern; non-BCD codes show a dash.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational (no latch).
    pattern = SEG_DASH;
    case (nibble)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with per-frame shadow latch.
// Define LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);

  localparam int                  CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [3:0]          AN_OFF   = {4{ACTIVE_LOW}};
  localparam logic [6:0]          SEG_OFF  = {7{ACTIVE_LOW}};

  logic [CNT_W-1:0] cnt;
  logic             slot_end;
  logic             frame_end;
  digit_idx_t       idx, idx_next;
  logic [15:0]      shadow_bcd;
  logic [3:0]       shadow_dp;

  logic [3:0]       nibble;
  logic             dp_sel;
  logic [6:0]       pattern;
  logic [3:0]       blank_vec;
  logic             digit_on;
  logic [3:0]       an_raw;
  logic             dp_raw;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == DIGIT_3);

  // NOTE: clocked state is always updated with non-blocking (<=) assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= DIGIT_0;
    end else begin
      idx <= idx_next;
    end
  end

  always_comb begin
    idx_next = idx;
    if (slot_end) begin
      case (idx)
        DIGIT_0: idx_next = DIGIT_1;
        DIGIT_1: idx_next = DIGIT_2;
        DIGIT_2: idx_next = DIGIT_3;
        DIGIT_3: idx_next = DIGIT_0;
        default: idx_next = DIGIT_0;
      endcase
    end
  end

  // NOTE: the shadow is reset too, so the first frame after reset shows a defined 0000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_bcd <= '0;
      shadow_dp  <= '0;
    end else if (frame_end) begin
      shadow_bcd <= bus.bcd_in;
      shadow_dp  <= bus.dp_in;
    end
  end

  always_comb begin
    nibble = shadow_bcd[3:0];
    dp_sel = shadow_dp[0];
    case (idx)
      DIGIT_0: begin nibble = shadow_bcd[3:0];   dp_sel = shadow_dp[0]; end
      DIGIT_1: begin nibble = shadow_bcd[7:4];   dp_sel = shadow_dp[1]; end
      DIGIT_2: begin nibble = shadow_bcd[11:8];  dp_sel = shadow_dp[2]; end
      DIGIT_3: begin nibble = shadow_bcd[15:12]; dp_sel = shadow_dp[3]; end
      default: begin nibble = shadow_bcd[3:0];   dp_sel = shadow_dp[0]; end
    endcase
  end

  seg7_decoder u_decoder (
    .nibble  (nibble),
    .pattern (pattern)
  );

`ifdef LZ_BLANK_EN
  // A digit is blanked only if it and every higher digit are zero; invalid codes count as non-zero.
  assign blank_vec[3] = (shadow_bcd[15:12] == 4'd0);
  assign blank_vec[2] = blank_vec[3] && (shadow_bcd[11:8] == 4'd0);
  assign blank_vec[1] = blank_vec[2] && (shadow_bcd[7:4] == 4'd0);
  assign blank_vec[0] = 1'b0;
`else
  assign blank_vec = 4'b0000;
`endif

  // First clock of each slot is a guard cycle so the previous digit never ghosts.
  assign digit_on = (cnt != '0) && !blank_vec[idx];
  assign an_raw   = digit_on ? (4'b0001 << idx) : 4'b0000;
  assign dp_raw   = digit_on && dp_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= AN_OFF;
      bus.seg        <= SEG_OFF;
      bus.dp         <= ACTIVE_LOW;
      bus.frame_tick <= 1'b0;
    end else begin
      bus.an         <= an_raw ^ {4{ACTIVE_LOW}};
      bus.seg        <= pattern ^ {7{ACTIVE_LOW}};
      bus.dp         <= dp_raw ^ ACTIVE_LOW;
      bus.frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: an active-low and an active-high instance,
// both with 4-clock slots, sampled on the falling clock edge.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if bus_l ();
  seg7_scan_driver_if bus_h ();

  seg7_scan_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );
  seg7_scan_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst_n(rst_n), .bus(bus_h)
  );

  logic [3:0] cap_an_l  [1:16];
  logic [6:0] cap_seg_l [1:16];
  logic       cap_dp_l  [1:16];
  logic       cap_ft_l  [1:16];
  logic [3:0] cap_an_h  [1:16];
  logic [6:0] cap_seg_h [1:16];
  logic       cap_dp_h  [1:16];
  logic       cap_ft_h  [1:16];

  // Hand-written active-high patterns, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] m_seg(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // Records one 16-clock frame from both instances; optionally changes bus_l.bcd_in mid-frame.
  task automatic capture_frame(input int change_at, input logic [15:0] new_bcd);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      cap_an_l[j] = bus_l.an;  cap_seg_l[j] = bus_l.seg;
      cap_dp_l[j] = bus_l.dp;  cap_ft_l[j]  = bus_l.frame_tick;
      cap_an_h[j] = bus_h.an;  cap_seg_h[j] = bus_h.seg;
      cap_dp_h[j] = bus_h.dp;  cap_ft_h[j]  = bus_h.frame_tick;
      if (j == change_at) bus_l.bcd_in = new_bcd;
    end
  endtask

  task automatic test_reset();
    bus_l.bcd_in = 16'h0000; bus_l.dp_in = 4'b0000;
    bus_h.bcd_in = 16'h0000; bus_h.dp_in = 4'b0000;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_l got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
               bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_tick);
    end
    n_cmp++;
    if ({bus_h.an, bus_h.seg, bus_h.dp, bus_h.frame_tick} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_h got an=%b seg=%b dp=%b ft=%b want all zero",
               bus_h.an, bus_h.seg, bus_h.dp, bus_h.frame_tick);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (bus_l.an !== 4'b1101) begin
      n_fail++;
      $display("FAIL pre_drop_an got %b want 1101", bus_l.an);
    end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_l got an=%b seg=%b dp=%b ft=%b want 1111 1111111 1 0",
               bus_l.an, bus_l.seg, bus_l.dp, bus_l.frame_tick);
    end
    n_cmp++;
    if ({bus_h.an, bus_h.dp} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset_h got an=%b dp=%b want 0000 0", bus_h.an, bus_h.dp);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus_l.an !== 4'hF) begin
      n_fail++;
      $display("FAIL guard_after_release got %b want 1111", bus_l.an);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus_l.an, bus_l.seg, bus_l.dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      n_fail++;
      $display("FAIL first_digit got an=%b seg=%b dp=%b want 1110 1000000 1",
               bus_l.an, bus_l.seg, bus_l.dp);
    end
    n_cmp++;
    if (bus_h.an !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_digit_h got %b want 0001", bus_h.an);
    end
  endtask

  task automatic test_steady_scan();
    bit found = 1'b0;
    bus_l.bcd_in = 16'h1234; bus_l.dp_in = 4'b0000;
    bus_h.bcd_in = 16'h9999; bus_h.dp_in = 4'b0100;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus_l.frame_tick === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL frame_tick_timeout got none in 40 clocks want one");
    end
    capture_frame(0, 16'h0000);
    for (int j = 1; j <= 16; j++) begin
      int k = (j - 1) / 4;
      bit on = ((j - 1) % 4) != 0;
      logic [3:0] oh = 4'b0001 << k;
      logic [15:0] v = 16'h1234;
      logic [3:0] exp_an = on ? ~oh : 4'hF;
      n_cmp++;
      if ({cap_an_l[j], cap_dp_l[j], cap_ft_l[j]} !== {exp_an, 1'b1, j == 16}) begin
        n_fail++;
        $display("FAIL steady an/dp/tick j=%0d got %b want %b", j,
                 {cap_an_l[j], cap_dp_l[j], cap_ft_l[j]}, {exp_an, 1'b1, j == 16});
      end
      if (on) begin
        n_cmp++;
        if (cap_seg_l[j] !== ~m_seg(v[k*4 +: 4])) begin
          n_fail++;
          $display("FAIL steady seg j=%0d got %b want %b", j, cap_seg_l[j], ~m_seg(v[k*4 +: 4]));
        end
      end
    end
  endtask

  task automatic test_dp_polarity();
    capture_frame(0, 16'h0000);
    for (int j = 1; j <= 16; j++) begin
      int k = (j - 1) / 4;
      bit on = ((j - 1) % 4) != 0;
      logic [3:0] oh = 4'b0001 << k;
      logic [3:0] exp_an = on ? oh : 4'h0;
      logic exp_dp = on && (k == 2);
      n_cmp++;
      if ({cap_an_h[j], cap_dp_h[j], cap_ft_h[j]} !== {exp_an, exp_dp, j == 16}) begin
        n_fail++;
        $display("FAIL polarity an/dp/tick j=%0d got %b want %b", j,
                 {cap_an_h[j], cap_dp_h[j], cap_ft_h[j]}, {exp_an, exp_dp, j == 16});
      end
      if (on) begin
        n_cmp++;
        if (cap_seg_h[j] !== 7'b1101111) begin
          n_fail++;
          $display("FAIL polarity seg j=%0d got %b want 1101111", j, cap_seg_h[j]);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    logic [15:0] frames [2];
    frames[0] = 16'h1234;
    frames[1] = 16'h5678;
    for (int f = 0; f < 2; f++) begin
      capture_frame(f == 0 ? 9 : 0, 16'h5678);
      for (int j = 1; j <= 16; j++) begin
        int k = (j - 1) / 4;
        bit on = ((j - 1) % 4) != 0;
        logic [15:0] v = frames[f];
        if (on) begin
          n_cmp++;
          if (cap_seg_l[j] !== ~m_seg(v[k*4 +: 4])) begin
            n_fail++;
            $display("FAIL tear_free frame%0d seg j=%0d got %b want %b", f, j,
                     cap_seg_l[j], ~m_seg(v[k*4 +: 4]));
          end
        end
      end
      n_cmp++;
      if (cap_ft_l[16] !== 1'b1) begin
        n_fail++;
        $display("FAIL tear_free frame%0d tick got %b want 1", f, cap_ft_l[16]);
      end
    end
  endtask

  task automatic test_invalid_nibble();
    logic [6:0] exp_seg [4];
    exp_seg[0] = 7'b0011001; exp_seg[1] = 7'b0111111;
    exp_seg[2] = 7'b0100100; exp_seg[3] = 7'b1111001;
    bus_l.bcd_in = 16'h12A4;
    capture_frame(0, 16'h0000);
    capture_frame(0, 16'h0000);
    for (int j = 2; j <= 16; j += 4) begin
      int k = (j - 1) / 4;
      n_cmp++;
      if (cap_seg_l[j] !== exp_seg[k]) begin
        n_fail++;
        $display("FAIL invalid slot%0d seg got %b want %b", k, cap_seg_l[j], exp_seg[k]);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] vals [2];
    logic [3:0]  blanks [2];
    vals[0] = 16'h0070;
    vals[1] = 16'h0000;
`ifdef LZ_BLANK_EN
    blanks[0] = 4'b1100;
    blanks[1] = 4'b1110;
`else
    blanks[0] = 4'b0000;
    blanks[1] = 4'b0000;
`endif
    bus_l.dp_in = 4'b1111;
    for (int t = 0; t < 2; t++) begin
      bus_l.bcd_in = vals[t];
      capture_frame(0, 16'h0000);
      capture_frame(0, 16'h0000);
      for (int j = 1; j <= 16; j++) begin
        int k = (j - 1) / 4;
        logic [3:0] bl = blanks[t];
        bit on = (((j - 1) % 4) != 0) && !bl[k];
        logic [3:0] oh = 4'b0001 << k;
        logic [15:0] v = vals[t];
        logic [3:0] exp_an = on ? ~oh : 4'hF;
        n_cmp++;
        if ({cap_an_l[j], cap_dp_l[j]} !== {exp_an, ~on}) begin
          n_fail++;
          $display("FAIL lz_%h an/dp j=%0d got %b want %b", v, j,
                   {cap_an_l[j], cap_dp_l[j]}, {exp_an, ~on});
        end
        if (on) begin
          n_cmp++;
          if (cap_seg_l[j] !== ~m_seg(v[k*4 +: 4])) begin
            n_fail++;
            $display("FAIL lz_%h seg j=%0d got %b want %b", v, j, cap_seg_l[j], ~m_seg(v[k*4 +: 4]));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady_scan();
    test_dp_polarity();
    test_tear_free();
    test_invalid_nibble();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 4-digit BCD event counter. Takes the packed 16-bit BCD count and time-multiplexes it onto a 4-digit common-anode seven-segment display. Each digit gets one slot in turn. The count is latched once per scan frame so the display never shows a torn value. Sits between the counter and the board display pins.

Parameters:
REFRESH_DIV, 100000, clocks per digit slot (100 MHz clock gives 1 kHz per digit, 250 Hz per frame); legal range >= 2.
ACTIVE_LOW, 1, 1 means an, seg and dp are driven active-low (board default); 0 means active-high.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bcd_in  input  16  packed BCD; [3:0] is the ones digit, [15:12] is the thousands digit
dp_in  input  4  decimal-point request per digit; bit i belongs to digit i
an  output  4  digit enables; an[0] is the ones digit
seg  output  7  segment pattern {g,f,e,d,c,b,a}
dp  output  1  decimal point of the currently enabled digit
frame_tick  output  1  one-clock pulse in the cycle the shadow register loads

Behaviour:
- Reset (async, rst_n=0). All outputs take these values immediately:
  - an, seg, dp all inactive (1111 / 7'h7F / 1 when ACTIVE_LOW=1).
  - prescaler=0, digit index=0, shadow BCD=0, shadow dp=0, frame_tick=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - slot_end is asserted when the count equals REFRESH_DIV-1.
- Digit index:
  - 2-bit state, sequence 0->1->2->3->0.
  - Advances on the edge where slot_end=1. No other state exists.
- Shadow latch:
  - On the edge where index goes 3->0, bcd_in and dp_in load into the shadow registers.
  - frame_tick is 1 for exactly that following cycle.
  - bcd_in changes at any other time are ignored until the next frame boundary.
- Ghost guard: an is all-inactive during the first clock of every slot (prescaler=0). It is active for the remaining REFRESH_DIV-1 clocks.
- Outputs are registered: one clock latency from index/shadow state to pins.
  - First slot after reset release starts with a guard cycle.
  - It then shows digit 0 of shadow=0.
- Decode per nibble:
  - 0-9 use standard patterns.
  - A-F (invalid BCD) show a dash: g only, active-high 7'b1000000.
- dp follows shadow dp[index].
- Polarity: when ACTIVE_LOW=1, an, seg and dp are inverted at the output register.
- Reset mid-slot forces the inactive outputs asynchronously. Scan restarts at digit 0 on release.

Optional Feature:
Macro LZ_BLANK_EN.
- Defined: leading-zero blanking, evaluated on the shadow register.
  - Digit i (i=3,2,1) is blanked (an stays inactive for the whole slot, dp also suppressed) when it and all higher digits equal 0.
  - Digit 0 is never blanked.
  - An invalid nibble counts as non-zero.
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - NUM_DIGITS=4
  - segment pattern constants SEG_0..SEG_9 and SEG_DASH (active-high, {g..a} order)
  - 2-bit digit index typedef
- Sub-module seg7_decoder: combinational 4-bit nibble to 7-bit active-high pattern with dash fallback. It is instantiated once, on the muxed shadow nibble.

Test Plan:
1. Async reset: run scan with REFRESH_DIV=4, drop rst_n mid-slot between clock edges -> an=1111, seg=7'h7F, dp=1, frame_tick=0 with no clock edge. Release -> first an=1110 appears after the guard cycle.
2. Steady scan: REFRESH_DIV=4, ACTIVE_LOW=1, bcd_in=16'h1234.
   - Required slot order: an=1110 with seg=7'b0011001 ('4'), then 1101 '3', then 1011 '2', then 0111 '1'.
   - Each slot is 4 clocks with the first clock an=1111.
   - Frame is 16 clocks; frame_tick pulses once per 16 clocks.
3. Tear-free: load 16'h1234 at a frame boundary, then change bcd_in to 16'h5678 during slot 2 -> slots 2,3 still show '2','1'. After the next frame_tick all four slots show 8,7,6,5.
4. Invalid nibble: bcd_in=16'h12A4 -> slot 1 shows seg=7'b0111111 (dash); the other digits are unaffected.
5. LZ_BLANK_EN defined:
   - bcd_in=16'h0070 -> slots 3,2 keep an=1111 for the whole slot even with dp_in=4'b1111; slots 1,0 show '7','0'.
   - bcd_in=16'h0000 -> only slot 0 is enabled, showing '0'.
   - Macro undefined -> 16'h0070 shows 0,0,7,0.
6. dp and polarity: ACTIVE_LOW=0, dp_in=4'b0100, bcd_in=16'h9999 -> dp=1 only during slot 2. seg=7'b1101111 ('9') in every slot; an is one-hot active-high.
